// File: rtl/dcache_wb_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : dcache_wb_buffer                                                |
// | Write-back FIFO between the dcache and the AXI bridge write request port. |
// | Optional line forwarding to refills: define DCACHE_WB_BUFFER_FWD_EN.      |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module dcache_wb_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         wb_req,
  input  logic         wb_type,
  input  logic [31:0]  wb_addr,
  input  logic [2:0]   wb_size,
  input  logic [3:0]   wb_wstrb,
  input  logic [255:0] wb_data,
  output logic         wb_ready,
  input  logic [31:0]  chk_addr,
  output logic         chk_hit,
  output logic         chk_fwd_valid,
  output logic [255:0] chk_fwd_data,
  output logic         wb_empty,
  output logic         data_wr_req,
  output logic         data_wr_type,
  output logic [31:0]  data_wr_addr,
  output logic [2:0]   data_wr_size,
  output logic [3:0]   data_wr_wstrb,
  output logic [255:0] data_wr_data,
  input  logic         data_wr_rdy,
  input  logic         data_wr_ok
);

  localparam logic [0:0]     c_st_idle = 1'b0;
  localparam logic [0:0]     c_st_sent = 1'b1;
  localparam logic [PTR_W:0] c_full    = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0] r_type;
  logic [31:0]      r_addr  [DEPTH];
  logic [2:0]       r_size  [DEPTH];
  logic [3:0]       r_wstrb [DEPTH];
  logic [255:0]     r_data  [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [0:0]       r_state;

  logic             w_push;
  logic             w_pop;
  logic             w_issue;
  logic [DEPTH-1:0] w_match;
  logic             w_unused_chk;

  assign wb_ready    = (r_count != c_full);
  assign wb_empty    = (r_count == '0);
  assign w_push      = wb_req && wb_ready;
  assign data_wr_req = (r_state == c_st_idle) && (r_count != '0);
  assign w_issue     = data_wr_req && data_wr_rdy;
  assign w_pop       = (r_state == c_st_sent) && data_wr_ok;

  assign data_wr_type  = r_type[r_rd_ptr];
  assign data_wr_addr  = r_addr[r_rd_ptr];
  assign data_wr_size  = r_size[r_rd_ptr];
  assign data_wr_wstrb = r_wstrb[r_rd_ptr];
  assign data_wr_data  = r_data[r_rd_ptr];

  // Payload storage is not reset; entry validity comes from rd_ptr/count.
  always_ff @(posedge clk) begin
    if (resetn && w_push) begin
      r_type[r_wr_ptr]  <= wb_type;
      r_addr[r_wr_ptr]  <= wb_addr;
      r_size[r_wr_ptr]  <= wb_type ? 3'd2 : wb_size;
      r_wstrb[r_wr_ptr] <= wb_type ? 4'hf : wb_wstrb;
      r_data[r_wr_ptr]  <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= c_st_idle;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      case (r_state)
        c_st_idle: if (w_issue) r_state <= c_st_sent;
        c_st_sent: if (w_pop)   r_state <= c_st_idle;
        default:                r_state <= c_st_idle;
      endcase
    end
  end

  // A slot is valid when its distance from rd_ptr is below count.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PTR_W'(i) - r_rd_ptr} < r_count &&
          r_addr[i][31:5] == chk_addr[31:5]) begin
        w_match[i] = 1'b1;
      end
    end
  end

  assign chk_hit      = |w_match;
  assign w_unused_chk = ^chk_addr[4:0];

`ifdef DCACHE_WB_BUFFER_FWD_EN
  logic             w_sel_found;
  logic [PTR_W-1:0] w_sel_idx;
  logic [PTR_W-1:0] w_idx;

  // Walk from oldest to youngest so the last match wins.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = r_rd_ptr;
    w_idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if (w_match[w_idx]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_idx;
      end
    end
  end

  assign chk_fwd_valid = w_sel_found && r_type[w_sel_idx];
  assign chk_fwd_data  = chk_fwd_valid ? r_data[w_sel_idx] : '0;
`else
  assign chk_fwd_valid = 1'b0;
  assign chk_fwd_data  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_wb_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_dcache_wb_buffer                                             |
// | Directed + random bench for dcache_wb_buffer against a queue model.      |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_dcache_wb_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic         clk = 1'b0;
  logic         resetn;
  logic         wb_req;
  logic         wb_type;
  logic [31:0]  wb_addr;
  logic [2:0]   wb_size;
  logic [3:0]   wb_wstrb;
  logic [255:0] wb_data;
  logic         wb_ready;
  logic [31:0]  chk_addr;
  logic         chk_hit;
  logic         chk_fwd_valid;
  logic [255:0] chk_fwd_data;
  logic         wb_empty;
  logic         data_wr_req;
  logic         data_wr_type;
  logic [31:0]  data_wr_addr;
  logic [2:0]   data_wr_size;
  logic [3:0]   data_wr_wstrb;
  logic [255:0] data_wr_data;
  logic         data_wr_rdy;
  logic         data_wr_ok;

  dcache_wb_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .resetn(resetn),
    .wb_req(wb_req), .wb_type(wb_type), .wb_addr(wb_addr), .wb_size(wb_size),
    .wb_wstrb(wb_wstrb), .wb_data(wb_data), .wb_ready(wb_ready),
    .chk_addr(chk_addr), .chk_hit(chk_hit), .chk_fwd_valid(chk_fwd_valid),
    .chk_fwd_data(chk_fwd_data), .wb_empty(wb_empty),
    .data_wr_req(data_wr_req), .data_wr_type(data_wr_type),
    .data_wr_addr(data_wr_addr), .data_wr_size(data_wr_size),
    .data_wr_wstrb(data_wr_wstrb), .data_wr_data(data_wr_data),
    .data_wr_rdy(data_wr_rdy), .data_wr_ok(data_wr_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         typ;
    logic [31:0]  addr;
    logic [2:0]   size;
    logic [3:0]   wstrb;
    logic [255:0] data;
  } ent_t;

  ent_t q[$];
  bit   m_sent = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Compare every output with the model, then advance one clock.
  task automatic step(input string tag);
    logic         e_hit;
    logic         e_fv;
    logic [255:0] e_fd;
    bit           was_full;
    ent_t         e;
    #1;
    chk({tag, ".ready"}, 256'(wb_ready), 256'(q.size() != DEPTH));
    chk({tag, ".empty"}, 256'(wb_empty), 256'(q.size() == 0));
    chk({tag, ".req"}, 256'(data_wr_req), 256'(!m_sent && q.size() != 0));
    if (!m_sent && q.size() != 0) begin
      chk({tag, ".type"}, 256'(data_wr_type), 256'(q[0].typ));
      chk({tag, ".addr"}, 256'(data_wr_addr), 256'(q[0].addr));
      chk({tag, ".size"}, 256'(data_wr_size), 256'(q[0].size));
      chk({tag, ".wstrb"}, 256'(data_wr_wstrb), 256'(q[0].wstrb));
      if (q[0].typ) chk({tag, ".data"}, data_wr_data, q[0].data);
      else          chk({tag, ".data"}, 256'(data_wr_data[31:0]), 256'(q[0].data[31:0]));
    end
    e_hit = 1'b0; e_fv = 1'b0; e_fd = '0;
    foreach (q[i]) begin
      if (q[i].addr[31:5] == chk_addr[31:5]) begin
        e_hit = 1'b1;
        e_fv  = q[i].typ;
        e_fd  = q[i].typ ? q[i].data : '0;
      end
    end
    chk({tag, ".hit"}, 256'(chk_hit), 256'(e_hit));
`ifdef DCACHE_WB_BUFFER_FWD_EN
    chk({tag, ".fwd_valid"}, 256'(chk_fwd_valid), 256'(e_fv));
    chk({tag, ".fwd_data"}, chk_fwd_data, e_fd);
`else
    chk({tag, ".fwd_valid"}, 256'(chk_fwd_valid), 256'(1'b0 & e_fv));
    chk({tag, ".fwd_data"}, chk_fwd_data, e_fd & '0);
`endif
    @(posedge clk);
    if (!resetn) begin
      q.delete();
      m_sent = 1'b0;
    end else begin
      was_full = (q.size() == DEPTH);
      if (m_sent && data_wr_ok) begin
        void'(q.pop_front());
        m_sent = 1'b0;
      end else if (!m_sent && q.size() != 0 && data_wr_rdy) begin
        m_sent = 1'b1;
      end
      if (wb_req && !was_full) begin
        e.typ   = wb_type;
        e.addr  = wb_addr;
        e.size  = wb_type ? 3'd2 : wb_size;
        e.wstrb = wb_type ? 4'hf : wb_wstrb;
        e.data  = wb_data;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic push(input logic t, input logic [31:0] a, input logic [2:0] s,
                      input logic [3:0] w, input logic [255:0] d);
    wb_req = 1'b1; wb_type = t; wb_addr = a; wb_size = s; wb_wstrb = w; wb_data = d;
  endtask

  function automatic logic [255:0] rnd_data();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic push_rand();
    logic t;
    logic [31:0] a;
    t = 1'($urandom_range(0, 1));
    a = 32'h4000_0000 | (32'($urandom_range(0, 7)) << 5);
    if (!t) a = a | (32'($urandom_range(0, 7)) << 2);
    push(t, a, 3'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), rnd_data());
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    wb_req = 1'b0;
    while (q.size() != 0 && n < 200) begin
      data_wr_rdy = 1'b1;
      data_wr_ok  = m_sent;
      step(tag);
      n++;
    end
    data_wr_ok = 1'b0;
    chk({tag, ".drain_bound"}, 256'(q.size()), 256'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d;
    logic [255:0] la;
    resetn = 1'b0; wb_req = 1'b0; wb_type = 1'b0; wb_addr = '0; wb_size = '0;
    wb_wstrb = '0; wb_data = '0; chk_addr = '0; data_wr_rdy = 1'b0; data_wr_ok = 1'b0;
    @(posedge clk);
    @(negedge clk);
    step("reset");
    resetn = 1'b1;

    // Single line write-back round trip.
    d = '0;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'h11 * (i + 1);
    push(1'b1, 32'h1000_0040, 3'd0, 4'h0, d);
    step("t1_push");
    wb_req = 1'b0; data_wr_rdy = 1'b1;
    #1;
    chk("t1_req_now", 256'(data_wr_req), 256'(1));
    chk("t1_addr_now", 256'(data_wr_addr), 256'(32'h1000_0040));
    chk("t1_size_now", 256'(data_wr_size), 256'(3'd2));
    chk("t1_wstrb_now", 256'(data_wr_wstrb), 256'(4'hf));
    step("t1_issue");
    data_wr_rdy = 1'b0;
    step("t1_sent");
    data_wr_ok = 1'b1;
    step("t1_ok");
    data_wr_ok = 1'b0;
    #1;
    chk("t1_empty_now", 256'(wb_empty), 256'(1));
    step("t1_empty");

    // Fill with the bridge busy, reject a fifth push, then drain in order.
    data_wr_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_rand();
      step("t2_fill");
    end
    push_rand();
    #1;
    chk("t2_full_ready", 256'(wb_ready), 256'(0));
    step("t2_fifth");
    drain("t2_drain");

    // Full with head in flight: completion and push in the same cycle pop only.
    data_wr_rdy = 1'b1;
    push_rand(); step("t3_e0");
    push_rand(); step("t3_e1");
    data_wr_rdy = 1'b0;
    push_rand(); step("t3_e2");
    push_rand(); step("t3_e3");
    push_rand();
    data_wr_ok = 1'b1;
    #1;
    chk("t3_full_ready", 256'(wb_ready), 256'(0));
    step("t3_pop_only");
    data_wr_ok = 1'b0;
    #1;
    chk("t3_ready_after_pop", 256'(wb_ready), 256'(1));
    step("t3_refill");
    wb_req = 1'b0;
    #1;
    chk("t3_full_again", 256'(wb_ready), 256'(0));
    step("t3_idle");
    drain("t3_drain");

    // Uncached word store.
    d = rnd_data();
    d[31:0] = 32'hDEAD_BEEF;
    push(1'b0, 32'h1FAF_F004, 3'd2, 4'b0011, d);
    step("t4_push");
    wb_req = 1'b0;
    #1;
    chk("t4_type", 256'(data_wr_type), 256'(0));
    chk("t4_addr", 256'(data_wr_addr), 256'(32'h1FAF_F004));
    chk("t4_wstrb", 256'(data_wr_wstrb), 256'(4'b0011));
    chk("t4_data", 256'(data_wr_data[31:0]), 256'(32'hDEAD_BEEF));
    step("t4_hold");
    drain("t4_drain");

    // Conflict check lifetime; a stray completion in IDLE is ignored.
    data_wr_rdy = 1'b0;
    push(1'b1, 32'h0000_2000, 3'd0, 4'h0, rnd_data());
    step("t5_push");
    wb_req = 1'b0;
    chk_addr = 32'h0000_2014;
    #1;
    chk("t5_hit_same_line", 256'(chk_hit), 256'(1));
    step("t5_a");
    chk_addr = 32'h0000_2020;
    #1;
    chk("t5_miss_next_line", 256'(chk_hit), 256'(0));
    step("t5_b");
    chk_addr = 32'h0000_2014;
    data_wr_ok = 1'b1;
    step("t5_stray_ok");
    data_wr_ok = 1'b0; data_wr_rdy = 1'b1;
    step("t5_issue");
    data_wr_rdy = 1'b0;
    #1;
    chk("t5_hit_sent", 256'(chk_hit), 256'(1));
    step("t5_sent");
    data_wr_ok = 1'b1;
    #1;
    chk("t5_hit_ok_cycle", 256'(chk_hit), 256'(1));
    step("t5_ok");
    data_wr_ok = 1'b0;
    #1;
    chk("t5_hit_gone", 256'(chk_hit), 256'(0));
    step("t5_gone");

    // Forwarding selection: youngest match decides.
    la = rnd_data();
    push(1'b1, 32'h0000_3000, 3'd0, 4'h0, la);
    step("t6_line");
    push(1'b0, 32'h0000_3008, 3'd2, 4'hf, rnd_data());
    step("t6_word");
    wb_req = 1'b0;
    chk_addr = 32'h0000_3000;
    #1;
    chk("t6_hit", 256'(chk_hit), 256'(1));
    chk("t6_fwd_word", 256'(chk_fwd_valid), 256'(0));
    step("t6_a");
    drain("t6_drain1");
    push(1'b1, 32'h0000_3000, 3'd0, 4'h0, la);
    step("t6_line_only");
    wb_req = 1'b0;
    #1;
`ifdef DCACHE_WB_BUFFER_FWD_EN
    chk("t6_fwd_line", 256'(chk_fwd_valid), 256'(1));
    chk("t6_fwd_data", chk_fwd_data, la);
`else
    chk("t6_fwd_line", 256'(chk_fwd_valid), 256'(0));
`endif
    step("t6_b");
    drain("t6_drain2");

    // Reset while entries are pending discards them.
    data_wr_rdy = 1'b1;
    push_rand(); step("t7_a");
    push_rand(); step("t7_b");
    wb_req = 1'b0; resetn = 1'b0;
    step("t7_reset");
    resetn = 1'b1;
    #1;
    chk("t7_empty_after_reset", 256'(wb_empty), 256'(1));
    step("t7_after");

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 1) == 1) push_rand();
      else wb_req = 1'b0;
      data_wr_rdy = ($urandom_range(0, 3) != 0);
      data_wr_ok  = m_sent && ($urandom_range(0, 2) == 0);
      chk_addr = 32'h4000_0000 | (32'($urandom_range(0, 8)) << 5) | 32'($urandom_range(0, 31));
      step("rand");
    end
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
